// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES registered carry slices,
// valid/ready on both sides. Define PIPE_ADDER_OVF_EN to add the signed-overflow output `ovf`.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W = (STAGES > 0) ? (WIDTH / STAGES) : 1;
  localparam int L = STAGES - 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic             adv;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];

  // Per-stage inputs: stage 0 sees the port operands, stage k sees stage k-1's registers.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [W:0]       slice [STAGES];

  assign adv       = !valid_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[L];
  assign sum       = sum_q[L];
  assign cout      = carry_q[L];

  // Next-state of every stage: subtract is folded in at entry as ~b plus inverted carry.
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~cin : cin;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = carry_q[k-1];
      src_s[k] = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]} + {{W{1'b0}}, src_c[k]};
      valid_d[k] = src_v[k];
      a_d[k]     = src_a[k];
      b_d[k]     = src_b[k];
      carry_d[k] = slice[k][W];
      sum_d[k]   = src_s[k];
      sum_d[k][k*W +: W] = slice[k][W-1:0];
    end
  end

  // Stage registers: synchronous clear, whole pipe advances together or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB recovered from the MSB sum bit; overflow when it differs from carry out.
  always_comb begin
    ovf_d = (src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1] ^ sum_d[L][WIDTH-1]) ^ carry_d[L];
  end

  // Overflow flag is registered alongside the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, streaming/stall/reset
// sequences on a 16/4 instance, and latency checks on 8/1 and 8/8 instances.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int L      = STAGES - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, cin, sub, cout;
  logic [WIDTH-1:0]  a, b, sum;

  logic              s_in_valid, s_cin, s_sub, s_out_ready;
  logic [7:0]        s_a, s_b;
  logic              r1_in_ready, r1_out_valid, r1_cout;
  logic              r8_in_ready, r8_out_valid, r8_cout;
  logic [7:0]        r1_sum, r8_sum;
`ifdef PIPE_ADDER_OVF_EN
  logic              ovf, ovf1, ovf8;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(r1_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(r1_out_valid), .out_ready(s_out_ready), .sum(r1_sum),
    .cout(r1_cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(r8_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(r8_out_valid), .out_ready(s_out_ready), .sum(r8_sum),
    .cout(r8_cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t        vecs [9];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pop    = 0;
  logic        mv [STAGES];
  logic [16:0] md [STAGES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
    logic [15:0] yy;
    logic        cc;
    yy = s ? ~y : y;
    cc = s ? ~c : c;
    return {1'b0, x} + {1'b0, yy} + {16'b0, cc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < STAGES; k++) begin
      mv[k] = 1'b0;
      md[k] = 17'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
  endtask

  // One clock of the 16/4 instance against a cycle-level flow-control model.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic is, input logic ordy, output logic acc);
    logic        adv;
    logic        stalled;
    logic [15:0] held;
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    adv = !mv[L] || ordy;
    check("in_ready", in_ready, adv);
    acc = iv && adv;
    if (out_valid && ordy) n_pop++;
    stalled = out_valid && !ordy;
    held = sum;
    @(posedge clk);
    if (adv) begin
      for (int k = L; k > 0; k--) begin
        mv[k] = mv[k-1];
        md[k] = md[k-1];
      end
      mv[0] = iv;
      md[0] = ref_op(ia, ib, ic, is);
    end
    #1;
    check("out_valid", out_valid, mv[L]);
    if (mv[L]) begin
      check("sum", sum, md[L][15:0]);
      check("cout", cout, md[L][16]);
    end
    if (stalled) check("stall_hold", sum, held);
  endtask

  initial begin
    logic        acc;
    logic [3:0]  pat;
    int          first_cyc, n_out, n_acc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    model_clear();
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_s1_in_ready", r1_in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;

    // Directed vectors, one at a time, with exact latency.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; a = vecs[i].va; b = vecs[i].vb; cin = vecs[i].vcin; sub = vecs[i].vsub;
      step();
      in_valid = 1'b0;
      for (int s = 1; s < STAGES; s++) begin
        check("vec_early_valid", out_valid, 1'b0);
        step();
      end
      check("vec_valid", out_valid, 1'b1);
      check("vec_sum", sum, vecs[i].esum);
      check("vec_cout", cout, vecs[i].ecout);
`ifdef PIPE_ADDER_OVF_EN
      check("vec_ovf", ovf, vecs[i].eovf);
`endif
    end

    // 20 back-to-back random beats with out_ready high.
    do_reset();
    first_cyc = -1; n_out = 0; n_acc = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(i < 20, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
      if (acc) n_acc++;
      if (out_valid) begin
        n_out++;
        if (first_cyc < 0) first_cyc = i + 1;
      end
    end
    check("stream_first_cycle", first_cyc, 4);
    check("stream_results", n_out, 20);
    check("stream_accepted", n_acc, 20);

    // Stream under out_ready pattern 1,0,0,1, then drain.
    do_reset();
    pat = 4'b1001; n_acc = 0; n_pop = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), pat[i % 4], acc);
      if (acc) n_acc++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, acc);
    end
    check("stall_no_loss", n_pop, n_acc);

    // Reset with three beats in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, 1'b1, acc);
    end
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, acc);
    end

    // 8-bit single-stage and eight-stage latency.
    s_in_valid = 1'b1; s_a = 8'h80; s_b = 8'h80;
    step();
    s_in_valid = 1'b0;
    check("s1_valid", r1_out_valid, 1'b1);
    check("s1_sum", r1_sum, 8'h00);
    check("s1_cout", r1_cout, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    check("s1_ovf", ovf1, 1'b1);
`endif
    for (int i = 2; i <= 7; i++) begin
      step();
      check("s8_early_valid", r8_out_valid, 1'b0);
    end
    step();
    check("s8_valid", r8_out_valid, 1'b1);
    check("s8_sum", r8_sum, 8'h00);
    check("s8_cout", r8_cout, 1'b1);
    check("s8_in_ready", r8_in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    check("s8_ovf", ovf8, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
